// File: rtl/alu_operand_stack_if.sv
// Command/data bus between the decoder/ALU and the operand stack.
// The decoder side is the master; the stack itself is the slave.
interface alu_operand_stack_if #(
    parameter int REG_BITS = 32,
    parameter int CNT_BITS = 5
);
    logic                cmd_valid;
    logic [2:0]          cmd;
    logic [REG_BITS-1:0] wdata;
    logic [REG_BITS-1:0] operand1;
    logic [REG_BITS-1:0] operand2;
    logic [CNT_BITS-1:0] count;
    logic                empty;
    logic                full;
    logic                cmd_ok;
    logic                overflow;
    logic                underflow;

    modport master (
        output cmd_valid, cmd, wdata,
        input  operand1, operand2, count, empty, full, cmd_ok, overflow, underflow
    );

    modport slave (
        input  cmd_valid, cmd, wdata,
        output operand1, operand2, count, empty, full, cmd_ok, overflow, underflow
    );
endinterface

// File: rtl/alu_operand_stack.sv
// Operand stack for the single-cycle stack datapath: exposes NOS/TOS to the ALU
// and commits results, pushes, pops, dup/swap and clear on the rising clock edge.
module alu_operand_stack #(
    parameter int REG_BITS = 32,
    parameter int DEPTH    = 16,
    parameter int CNT_BITS = 5
) (
    input  logic               clk,
    input  logic               reset,
    alu_operand_stack_if.slave bus
);
    localparam int IDX_BITS = $clog2(DEPTH);
    localparam logic [CNT_BITS-1:0] DEPTH_CNT = CNT_BITS'(DEPTH);
    localparam logic [CNT_BITS-1:0] ONE       = CNT_BITS'(1);
    localparam logic [CNT_BITS-1:0] TWO       = CNT_BITS'(2);

    typedef enum logic [2:0] {
        CMD_NOP     = 3'b000,
        CMD_PUSH    = 3'b001,
        CMD_POP     = 3'b010,
        CMD_BINOP   = 3'b011,
        CMD_REPLACE = 3'b100,
        CMD_DUP     = 3'b101,
        CMD_SWAP    = 3'b110,
        CMD_CLEAR   = 3'b111
    } cmd_e;

    logic [REG_BITS-1:0] mem_q [DEPTH];
    logic [REG_BITS-1:0] mem_d [DEPTH];
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                cmd_ok_q, cmd_ok_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;

    cmd_e                cmd_sel;
    logic                has_one, has_two, is_full;
    logic [IDX_BITS-1:0] tos_idx, nos_idx, push_idx;

    assign cmd_sel = cmd_e'(bus.cmd);

    // Occupancy predicates and the three slot indices the commands address.
    always_comb begin
        has_one  = (count_q != '0);
        has_two  = (count_q >= TWO);
        is_full  = (count_q == DEPTH_CNT);
        tos_idx  = has_one ? IDX_BITS'(count_q - ONE) : '0;
        nos_idx  = has_two ? IDX_BITS'(count_q - TWO) : '0;
        push_idx = is_full ? '0 : IDX_BITS'(count_q);
    end

    // Operands come only from registered state, so the ALU->wdata path never loops.
    always_comb begin
        bus.operand1  = has_two ? mem_q[nos_idx] : '0;
        bus.operand2  = has_one ? mem_q[tos_idx] : '0;
        bus.count     = count_q;
        bus.empty     = !has_one;
        bus.full      = is_full;
        bus.cmd_ok    = cmd_ok_q;
        bus.overflow  = overflow_q;
        bus.underflow = underflow_q;
    end

    always_comb begin
        mem_d       = mem_q;
        count_d     = count_q;
        cmd_ok_d    = cmd_ok_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (bus.cmd_valid) begin
            cmd_ok_d = 1'b1;
            unique case (cmd_sel)
                CMD_NOP: begin
                end
                CMD_PUSH: begin
                    if (!is_full) begin
                        mem_d[push_idx] = bus.wdata;
                        count_d         = count_q + ONE;
                    end else begin
                        cmd_ok_d   = 1'b0;
                        overflow_d = 1'b1;
                    end
                end
                CMD_POP: begin
                    if (has_one) begin
                        count_d = count_q - ONE;
                    end else begin
                        cmd_ok_d    = 1'b0;
                        underflow_d = 1'b1;
                    end
                end
                CMD_BINOP: begin
                    if (has_two) begin
                        mem_d[nos_idx] = bus.wdata;
                        count_d        = count_q - ONE;
                    end else begin
                        cmd_ok_d    = 1'b0;
                        underflow_d = 1'b1;
                    end
                end
                CMD_REPLACE: begin
                    if (has_one) begin
                        mem_d[tos_idx] = bus.wdata;
                    end else begin
                        cmd_ok_d    = 1'b0;
                        underflow_d = 1'b1;
                    end
                end
                CMD_DUP: begin
                    // Empty takes priority: with nothing to copy it is an underflow.
                    if (!has_one) begin
                        cmd_ok_d    = 1'b0;
                        underflow_d = 1'b1;
                    end else if (is_full) begin
                        cmd_ok_d   = 1'b0;
                        overflow_d = 1'b1;
                    end else begin
                        mem_d[push_idx] = mem_q[tos_idx];
                        count_d         = count_q + ONE;
                    end
                end
                CMD_SWAP: begin
                    if (has_two) begin
                        mem_d[tos_idx] = mem_q[nos_idx];
                        mem_d[nos_idx] = mem_q[tos_idx];
                    end else begin
                        cmd_ok_d    = 1'b0;
                        underflow_d = 1'b1;
                    end
                end
                CMD_CLEAR: begin
                    count_d = '0;
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q     <= '0;
            cmd_ok_q    <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            cmd_ok_q    <= cmd_ok_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage needs no reset: count=0 masks whatever it holds.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: tb/tb_alu_operand_stack.sv
// Self-checking bench for alu_operand_stack: directed scenarios followed by
// random commands, all compared against a queue-based stack model.
module tb_alu_operand_stack;
    localparam int REG_BITS = 32;
    localparam int DEPTH    = 16;
    localparam int CNT_BITS = 5;

    localparam logic [2:0] NOP = 3'd0, PUSH = 3'd1, POP = 3'd2, BINOP = 3'd3,
                           REPLACE = 3'd4, DUP = 3'd5, SWAP = 3'd6, CLEAR = 3'd7;

    logic clk;
    logic reset;

    alu_operand_stack_if #(.REG_BITS(REG_BITS), .CNT_BITS(CNT_BITS)) bus_if ();

    alu_operand_stack #(.REG_BITS(REG_BITS), .DEPTH(DEPTH), .CNT_BITS(CNT_BITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [REG_BITS-1:0] model_stack[$];
    logic                model_ok;
    logic                model_ovf;
    logic                model_unf;

    // Stack semantics expressed directly on a queue whose back is the top.
    task automatic model_step(input logic valid, input logic [2:0] c,
                              input logic [REG_BITS-1:0] w, input logic rst);
        int n;
        logic [REG_BITS-1:0] tmp;
        n = model_stack.size();
        if (rst) begin
            model_stack.delete();
            model_ok  = 1'b0;
            model_ovf = 1'b0;
            model_unf = 1'b0;
            return;
        end
        if (!valid) return;
        model_ok = 1'b1;
        case (c)
            NOP: ;
            PUSH:
                if (n < DEPTH) model_stack.push_back(w);
                else begin model_ok = 1'b0; model_ovf = 1'b1; end
            POP:
                if (n >= 1) void'(model_stack.pop_back());
                else begin model_ok = 1'b0; model_unf = 1'b1; end
            BINOP:
                if (n >= 2) begin
                    void'(model_stack.pop_back());
                    model_stack[n-2] = w;
                end else begin model_ok = 1'b0; model_unf = 1'b1; end
            REPLACE:
                if (n >= 1) model_stack[n-1] = w;
                else begin model_ok = 1'b0; model_unf = 1'b1; end
            DUP:
                if (n == 0) begin model_ok = 1'b0; model_unf = 1'b1; end
                else if (n == DEPTH) begin model_ok = 1'b0; model_ovf = 1'b1; end
                else model_stack.push_back(model_stack[n-1]);
            SWAP:
                if (n >= 2) begin
                    tmp              = model_stack[n-1];
                    model_stack[n-1] = model_stack[n-2];
                    model_stack[n-2] = tmp;
                end else begin model_ok = 1'b0; model_unf = 1'b1; end
            default: model_stack.delete();
        endcase
    endtask

    task automatic check_value(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_output(input string tag);
        int n;
        logic [REG_BITS-1:0] exp_op1, exp_op2;
        n       = model_stack.size();
        exp_op1 = (n >= 2) ? model_stack[n-2] : '0;
        exp_op2 = (n >= 1) ? model_stack[n-1] : '0;
        check_value({tag, ".count"},     64'(bus_if.count),     64'(n));
        check_value({tag, ".operand1"},  64'(bus_if.operand1),  64'(exp_op1));
        check_value({tag, ".operand2"},  64'(bus_if.operand2),  64'(exp_op2));
        check_value({tag, ".empty"},     64'(bus_if.empty),     64'(n == 0));
        check_value({tag, ".full"},      64'(bus_if.full),      64'(n == DEPTH));
        check_value({tag, ".cmd_ok"},    64'(bus_if.cmd_ok),    64'(model_ok));
        check_value({tag, ".overflow"},  64'(bus_if.overflow),  64'(model_ovf));
        check_value({tag, ".underflow"}, 64'(bus_if.underflow), 64'(model_unf));
    endtask

    // Drive one cycle of inputs, let the edge happen, then advance the model.
    task automatic apply_stimulus(input logic valid, input logic [2:0] c,
                                  input logic [REG_BITS-1:0] w, input logic rst);
        reset            = rst;
        bus_if.cmd_valid = valid;
        bus_if.cmd       = c;
        bus_if.wdata     = w;
        @(posedge clk);
        #1;
        model_step(valid, c, w, rst);
        reset            = 1'b0;
        bus_if.cmd_valid = 1'b0;
    endtask

    initial begin
        logic [2:0] rc;
        reset            = 1'b1;
        bus_if.cmd_valid = 1'b0;
        bus_if.cmd       = NOP;
        bus_if.wdata     = '0;
        model_stack.delete();
        model_ok = 1'b0; model_ovf = 1'b0; model_unf = 1'b0;

        apply_stimulus(1'b0, NOP, 0, 1'b1);
        check_output("reset");

        apply_stimulus(1'b1, PUSH, 5, 1'b0);
        apply_stimulus(1'b1, PUSH, 3, 1'b0);
        check_output("push2");
        check_value("push2.nos_lit", 64'(bus_if.operand1), 64'd5);
        check_value("push2.tos_lit", 64'(bus_if.operand2), 64'd3);
        apply_stimulus(1'b1, BINOP, 8, 1'b0);
        check_output("binop_at2");
        check_value("binop_at2.tos_lit", 64'(bus_if.operand2), 64'd8);
        check_value("binop_at2.cnt_lit", 64'(bus_if.count), 64'd1);

        apply_stimulus(1'b1, PUSH, 7, 1'b0);
        apply_stimulus(1'b1, REPLACE, 32'hFFFF_FFF8, 1'b0);
        check_output("replace");
        apply_stimulus(1'b1, DUP, 0, 1'b0);
        check_output("dup");
        apply_stimulus(1'b1, PUSH, 1, 1'b0);
        apply_stimulus(1'b1, SWAP, 0, 1'b0);
        check_output("swap");
        check_value("swap.tos_lit", 64'(bus_if.operand2), 64'hFFFF_FFF8);
        check_value("swap.nos_lit", 64'(bus_if.operand1), 64'd1);

        apply_stimulus(1'b0, NOP, 0, 1'b1);
        for (int i = 0; i < DEPTH; i++) apply_stimulus(1'b1, PUSH, REG_BITS'(i), 1'b0);
        check_output("fill");
        apply_stimulus(1'b1, PUSH, 99, 1'b0);
        check_output("push_full");
        check_value("push_full.ovf_lit", 64'(bus_if.overflow), 64'd1);
        apply_stimulus(1'b1, DUP, 0, 1'b0);
        check_output("dup_full");
        apply_stimulus(1'b1, POP, 0, 1'b0);
        check_output("pop_after_full");
        check_value("pop_after_full.tos_lit", 64'(bus_if.operand2), 64'd14);

        apply_stimulus(1'b0, NOP, 0, 1'b1);
        apply_stimulus(1'b1, POP, 0, 1'b0);
        check_output("empty_pop");
        apply_stimulus(1'b1, BINOP, 0, 1'b0);
        check_output("empty_binop");
        apply_stimulus(1'b1, SWAP, 0, 1'b0);
        check_output("empty_swap");
        apply_stimulus(1'b1, DUP, 0, 1'b0);
        check_output("empty_dup");
        check_value("empty_dup.ovf_lit", 64'(bus_if.overflow), 64'd0);
        apply_stimulus(1'b1, REPLACE, 9, 1'b0);
        check_output("empty_replace");
        apply_stimulus(1'b1, PUSH, 42, 1'b0);
        apply_stimulus(1'b1, BINOP, 77, 1'b0);
        check_output("binop_at1");
        apply_stimulus(1'b1, NOP, 0, 1'b0);
        check_output("nop_ok");

        apply_stimulus(1'b0, NOP, 0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            apply_stimulus(1'b1, PUSH, 4, 1'b0);
            apply_stimulus(1'b0, PUSH, 123, 1'b0);
            check_output("gated_push");
        end
        apply_stimulus(1'b1, POP, 0, 1'b0);
        apply_stimulus(1'b1, POP, 0, 1'b0);
        apply_stimulus(1'b1, POP, 0, 1'b0);
        apply_stimulus(1'b1, POP, 0, 1'b0);
        apply_stimulus(1'b1, POP, 0, 1'b0);
        apply_stimulus(1'b1, CLEAR, 0, 1'b0);
        check_output("clear_keeps_flags");

        for (int i = 0; i < 3; i++) apply_stimulus(1'b1, PUSH, $urandom, 1'b0);
        apply_stimulus(1'b1, PUSH, 55, 1'b1);
        check_output("reset_wins");

        for (int i = 0; i < 800; i++) begin
            rc = 3'($urandom_range(0, 7));
            if (rc == CLEAR && $urandom_range(0, 3) != 0) rc = PUSH;
            apply_stimulus($urandom_range(0, 9) != 0, rc, $urandom,
                           $urandom_range(0, 199) == 0);
            check_output("random");
        end

        $display("[TB] directed and random sequences complete");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
